debug_snapshot_tx: RTL and testbench

//  Downstream consumer of the core's debug taps (pc, last_pc, opcode, bus addr/data, lcdc, stat, ppu_state).
//  On a snap request it latches all taps in one cycle and streams them as one ASCII hex line over UART 8N1.

---
 rtl/debug_snapshot_tx_pkg.sv | 68 ++++++
 rtl/debug_snapshot_tx_uart_tx_byte.sv | 69 ++++++
 rtl/debug_snapshot_tx.sv | 108 ++++++++++
 tb/tb_debug_snapshot_tx.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_snapshot_tx_pkg.sv
// Shared constants, FSM state type, snapshot payload and ASCII line formatting for debug_snapshot_tx.
package debug_snapshot_tx_pkg;

  localparam int unsigned LINE_LEN = 31;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned NIB_BITS = 88;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_FIN
  } state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] last_pc;
    logic [7:0]  opcode;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  lcdc;
    logic [7:0]  stat;
    logic [4:0]  ppu_state;
  } snap_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n, input logic upper);
    if (n < 4'd10) return ASCII_ZERO + 8'(n);
    return (upper ? ASCII_UPPER_A : ASCII_LOWER_A) + 8'(n - 4'd10);
  endfunction

  // Character idx of "PPPP LLLL OO AAAA DD CC SS TT\r\n" for snapshot s.
  function automatic logic [7:0] line_char(input snap_t s, input logic [IDX_W-1:0] idx,
                                           input logic upper);
    logic [NIB_BITS-1:0] nib;
    logic [IDX_W-1:0]    ni;
    logic [6:0]          pos;
    logic [7:0]          ch;
    nib = {s.pc, s.last_pc, s.opcode, s.addr, s.data, s.lcdc, s.stat, 3'b000, s.ppu_state};
    ni  = '0;
    case (idx)
      5'd0, 5'd1, 5'd2, 5'd3:     ni = idx;
      5'd5, 5'd6, 5'd7, 5'd8:     ni = idx - 5'd1;
      5'd10, 5'd11:               ni = idx - 5'd2;
      5'd13, 5'd14, 5'd15, 5'd16: ni = idx - 5'd3;
      5'd18, 5'd19:               ni = idx - 5'd4;
      5'd21, 5'd22:               ni = idx - 5'd5;
      5'd24, 5'd25:               ni = idx - 5'd6;
      5'd27, 5'd28:               ni = idx - 5'd7;
      default:                    ni = '0;
    endcase
    pos = 7'd84 - {ni, 2'b00};
    case (idx)
      5'd4, 5'd9, 5'd12, 5'd17, 5'd20, 5'd23, 5'd26, 5'd31: ch = ASCII_SPACE;
      5'd29:   ch = ASCII_CR;
      5'd30:   ch = ASCII_LF;
      default: ch = hex_ascii(nib[pos +: 4], upper);
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/debug_snapshot_tx_uart_tx_byte.sv
// UART 8N1 byte transmitter; ready is high in idle and in the last cycle of the stop bit,
// so a load then starts the next start bit with no gap.
module uart_tx_byte #(
  parameter int unsigned BAUD_DIV = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_byte,
  input  logic       load,
  output logic       tx,
  output logic       ready
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_DIV - 1);

  logic             active, active_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       bits_left, bits_n;
  logic [8:0]       shreg, shreg_n;
  logic             tx_n, ready_n;

  // Frame register: start bit driven on load, then 8 data bits and the stop bit shifted out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      cnt       <= '0;
      bits_left <= '0;
      shreg     <= '0;
      tx        <= 1'b1;
      ready     <= 1'b1;
    end else begin
      active    <= active_n;
      cnt       <= cnt_n;
      bits_left <= bits_n;
      shreg     <= shreg_n;
      tx        <= tx_n;
      ready     <= ready_n;
    end
  end

  always_comb begin
    active_n = active;
    cnt_n    = cnt;
    bits_n   = bits_left;
    shreg_n  = shreg;
    tx_n     = tx;
    if (load && ready) begin
      active_n = 1'b1;
      cnt_n    = RELOAD;
      bits_n   = 4'd9;
      shreg_n  = {1'b1, tx_byte};
      tx_n     = 1'b0;
    end else if (active) begin
      if (cnt != '0) begin
        cnt_n = cnt - 1'b1;
      end else if (bits_left != '0) begin
        tx_n    = shreg[0];
        shreg_n = {1'b1, shreg[8:1]};
        bits_n  = bits_left - 4'd1;
        cnt_n   = RELOAD;
      end else begin
        active_n = 1'b0;
      end
    end
    ready_n = !active_n || ((bits_n == '0) && (cnt_n == '0));
  end

endmodule

// File: rtl/debug_snapshot_tx.sv
// Captures the core debug taps on snap and streams them as one ASCII hex line over UART 8N1.
module debug_snapshot_tx
  import debug_snapshot_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = 104,
  parameter bit          UPPERCASE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snap,
  input  logic [15:0] pc,
  input  logic [15:0] last_pc,
  input  logic [7:0]  opcode,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  input  logic [7:0]  lcdc,
  input  logic [7:0]  stat,
  input  logic [4:0]  ppu_state,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  snap_t            snapshot;
  snap_t            taps_c, char_src_c;
  logic [IDX_W-1:0] char_idx_c;
  logic [7:0]       char_c;
  logic             accept_c, uart_load_c, uart_ready;

  always_comb begin
    taps_c.pc        = pc;
    taps_c.last_pc   = last_pc;
    taps_c.opcode    = opcode;
    taps_c.addr      = addr;
    taps_c.data      = data;
    taps_c.lcdc      = lcdc;
    taps_c.stat      = stat;
    taps_c.ppu_state = ppu_state;
  end

  assign accept_c = snap && ((state == ST_IDLE) || (state == ST_FIN));

  // First character comes straight from the live taps so its start bit leaves on the capture edge.
  always_comb begin
    char_src_c  = snapshot;
    char_idx_c  = idx + 5'd1;
    uart_load_c = 1'b0;
    if (accept_c) begin
      char_src_c  = taps_c;
      char_idx_c  = '0;
      uart_load_c = 1'b1;
    end else if ((state == ST_SEND) && uart_ready && (idx != LAST_IDX)) begin
      uart_load_c = 1'b1;
    end
    char_c = line_char(char_src_c, char_idx_c, UPPERCASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      snapshot <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_FIN: begin
          if (snap) begin
            snapshot <= taps_c;
            idx      <= '0;
            busy     <= 1'b1;
            state    <= ST_SEND;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_SEND: begin
          if (uart_ready) begin
            if (idx == LAST_IDX) begin
              state <= ST_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart (
    .clk    (clk),
    .rst_n  (rst_n),
    .tx_byte(char_c),
    .load   (uart_load_c),
    .tx     (tx),
    .ready  (uart_ready)
  );

endmodule

// File: tb/tb_debug_snapshot_tx.sv
// Bench for debug_snapshot_tx: mid-bit UART receiver checks each line against a queue of expected bytes.
module tb_debug_snapshot_tx;

  localparam int unsigned BAUD_DIV = 4;
  localparam int unsigned LINE_LEN = 31;
  localparam int unsigned LINE_CYC = 310 * BAUD_DIV;
  localparam int unsigned RX_TMO   = 300;

  logic        clk = 1'b0;
  logic        rst_n, snap, snap_lc;
  logic [15:0] pc, last_pc, addr;
  logic [7:0]  opcode, data, lcdc, stat;
  logic [4:0]  ppu_state;
  logic        tx, busy, done, tx_lc, busy_lc, done_lc;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0, done_cnt_lc = 0, last_done_cyc = -1, busy_rise = -1, busy_fall = -1;
  logic busy_q = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debug_snapshot_tx #(.BAUD_DIV(BAUD_DIV), .UPPERCASE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .snap(snap), .pc(pc), .last_pc(last_pc), .opcode(opcode),
    .addr(addr), .data(data), .lcdc(lcdc), .stat(stat), .ppu_state(ppu_state),
    .tx(tx), .busy(busy), .done(done));

  debug_snapshot_tx #(.BAUD_DIV(BAUD_DIV), .UPPERCASE(1'b0)) dut_lc (
    .clk(clk), .rst_n(rst_n), .snap(snap_lc), .pc(pc), .last_pc(last_pc), .opcode(opcode),
    .addr(addr), .data(data), .lcdc(lcdc), .stat(stat), .ppu_state(ppu_state),
    .tx(tx_lc), .busy(busy_lc), .done(done_lc));

  // Record done pulses and busy edges of the uppercase instance.
  always @(negedge clk) begin
    if (done) begin
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
    end
    if (done_lc) done_cnt_lc = done_cnt_lc + 1;
    if (busy && !busy_q) busy_rise = cyc;
    if (!busy && busy_q) busy_fall = cyc;
    busy_q = busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  function automatic logic cur_tx(input bit lc);
    return lc ? tx_lc : tx;
  endfunction

  function automatic void push_line(input logic [15:0] p, input logic [15:0] l, input logic [7:0] o,
                                    input logic [15:0] a, input logic [7:0] d, input logic [7:0] c,
                                    input logic [7:0] s, input logic [4:0] t, input bit upper);
    string str;
    logic [7:0] ch;
    str = $sformatf("%04h %04h %02h %04h %02h %02h %02h %02h", p, l, o, a, d, c, s, {3'b000, t});
    for (int i = 0; i < str.len(); i++) begin
      ch = str[i];
      if (upper && ch >= 8'h61 && ch <= 8'h66) ch = ch - 8'h20;
      exp_q.push_back(ch);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic set_taps(input logic [15:0] p, input logic [15:0] l, input logic [7:0] o,
                          input logic [15:0] a, input logic [7:0] d, input logic [7:0] c,
                          input logic [7:0] s, input logic [4:0] t);
    pc = p; last_pc = l; opcode = o; addr = a; data = d; lcdc = c; stat = s; ppu_state = t;
  endtask

  // Receive one frame; every cycle of every bit is sampled so a short or long bit flags ferr.
  task automatic rx_byte(input bit lc, output logic [7:0] b, output int start_cyc,
                         output bit ferr, output bit tmo);
    bit found;
    logic [3:0] smp;
    logic [9:0] fr;
    found = 0; ferr = 0; tmo = 0; b = '0; start_cyc = -1; fr = '0;
    for (int w = 0; w < RX_TMO && !found; w++) begin
      @(negedge clk);
      if (cur_tx(lc) === 1'b0) found = 1;
    end
    if (!found) begin
      tmo = 1;
      return;
    end
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        smp[c] = cur_tx(lc);
      end
      if (smp !== {4{smp[0]}}) ferr = 1;
      fr[i] = smp[2];
    end
    if (fr[0] !== 1'b0 || fr[9] !== 1'b1) ferr = 1;
    b = fr[8:1];
  endtask

  task automatic test_reset();
    int k, lows;
    rst_n = 1'b0; snap = 1'b0; snap_lc = 1'b0;
    set_taps(16'h0, 16'h0, 8'h0, 16'h0, 8'h0, 8'h0, 8'h0, 5'h0);
    repeat (3) @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    rst_n = 1'b1;
    set_taps(16'hFFFF, 16'hFFFF, 8'hFF, 16'hFFFF, 8'hFF, 8'hFF, 8'hFF, 5'h1F);
    @(posedge clk); #1; k = cyc; snap = 1'b1;
    @(posedge clk); #1; snap = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL reset_pre_tx cycle %0d got %b want 0", cyc - k, tx); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_async_tx got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_async_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_async_done got %b want 0", done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    n_cmp++; if (lows !== 0) begin n_bad++; $display("FAIL reset_no_resume active_samples got %0d want 0", lows); end
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL reset_no_done got %0d want 0", done_cnt); end
  endtask

  task automatic test_basic();
    logic [7:0] b, e;
    int st, first_st, k, d0, ferrs;
    bit ferr, tmo;
    exp_q.delete();
    set_taps(16'h1234, 16'h0150, 8'hC3, 16'hFF40, 8'h91, 8'h91, 8'h85, 5'd5);
    push_line(16'h1234, 16'h0150, 8'hC3, 16'hFF40, 8'h91, 8'h91, 8'h85, 5'd5, 1'b1);
    d0 = done_cnt; ferrs = 0; first_st = -1;
    @(posedge clk); #1; k = cyc; snap = 1'b1;
    @(posedge clk); #1; snap = 1'b0;
    for (int i = 0; i < LINE_LEN; i++) begin
      rx_byte(1'b0, b, st, ferr, tmo);
      if (tmo) begin
        n_cmp++; n_bad++; $display("FAIL basic_timeout byte %0d", i);
        break;
      end
      if (i == 0) first_st = st;
      if (ferr) ferrs++;
      e = exp_q.pop_front();
      n_cmp++; if (b !== e) begin n_bad++; $display("FAIL basic_char[%0d] got %h want %h", i, b, e); end
    end
    repeat (4) @(negedge clk);
    n_cmp++; if (first_st - k !== 1) begin n_bad++; $display("FAIL basic_latency got %0d want 1", first_st - k); end
    n_cmp++; if (last_done_cyc - k !== 1 + LINE_CYC) begin n_bad++; $display("FAIL basic_done_cycle got %0d want %0d", last_done_cyc - k, 1 + LINE_CYC); end
    n_cmp++; if (busy_rise - k !== 1) begin n_bad++; $display("FAIL basic_busy_rise got %0d want 1", busy_rise - k); end
    n_cmp++; if (busy_fall - k !== 1 + LINE_CYC) begin n_bad++; $display("FAIL basic_busy_fall got %0d want %0d", busy_fall - k, 1 + LINE_CYC); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL basic_done_pulse got %0d want 1", done_cnt - d0); end
    n_cmp++; if (ferrs !== 0) begin n_bad++; $display("FAIL basic_framing got %0d want 0", ferrs); end
  endtask

  task automatic test_lowercase();
    logic [7:0] b, e;
    int st, d0, badc;
    bit ferr, tmo;
    exp_q.delete();
    set_taps(16'hABCD, 16'h0, 8'h0, 16'h0, 8'h0, 8'h0, 8'h0, 5'h0);
    push_line(16'hABCD, 16'h0, 8'h0, 16'h0, 8'h0, 8'h0, 8'h0, 5'h0, 1'b0);
    d0 = done_cnt_lc; badc = 0;
    @(posedge clk); #1; snap_lc = 1'b1;
    @(posedge clk); #1; snap_lc = 1'b0;
    for (int i = 0; i < LINE_LEN; i++) begin
      rx_byte(1'b1, b, st, ferr, tmo);
      if (tmo) begin
        n_cmp++; n_bad++; $display("FAIL lower_timeout byte %0d", i);
        break;
      end
      if (i == 0) begin
        n_cmp++; if (busy_lc !== 1'b1) begin n_bad++; $display("FAIL lower_busy got %b want 1", busy_lc); end
      end
      if (i < 29 && !(b == 8'h20 || (b >= 8'h30 && b <= 8'h39) || (b >= 8'h61 && b <= 8'h66))) badc++;
      e = exp_q.pop_front();
      n_cmp++; if (b !== e) begin n_bad++; $display("FAIL lower_char[%0d] got %h want %h", i, b, e); end
    end
    repeat (4) @(negedge clk);
    n_cmp++; if (badc !== 0) begin n_bad++; $display("FAIL lower_charset got %0d bad want 0", badc); end
    n_cmp++; if (done_cnt_lc - d0 !== 1) begin n_bad++; $display("FAIL lower_done got %0d want 1", done_cnt_lc - d0); end
    n_cmp++; if (busy_lc !== 1'b0) begin n_bad++; $display("FAIL lower_busy_end got %b want 0", busy_lc); end
  endtask

  task automatic test_no_requeue();
    logic [7:0] b, e;
    int st, d0, lows;
    bit ferr, tmo;
    exp_q.delete();
    set_taps(16'h5A5A, 16'h0100, 8'h3E, 16'hC000, 8'h7F, 8'h80, 8'h02, 5'd3);
    push_line(16'h5A5A, 16'h0100, 8'h3E, 16'hC000, 8'h7F, 8'h80, 8'h02, 5'd3, 1'b1);
    d0 = done_cnt;
    @(posedge clk); #1; snap = 1'b1;
    fork
      begin
        @(posedge clk); #1; snap = 1'b0;
        @(posedge clk); #1;
        set_taps(16'h9999, 16'h8888, 8'h77, 16'h6666, 8'h55, 8'h44, 8'h33, 5'd22);
        repeat (498) @(posedge clk);
        #1 snap = 1'b1;
        @(posedge clk); #1; snap = 1'b0;
      end
      begin
        for (int i = 0; i < LINE_LEN; i++) begin
          rx_byte(1'b0, b, st, ferr, tmo);
          if (tmo) begin
            n_cmp++; n_bad++; $display("FAIL requeue_timeout byte %0d", i);
            break;
          end
          e = exp_q.pop_front();
          n_cmp++; if (b !== e) begin n_bad++; $display("FAIL requeue_char[%0d] got %h want %h", i, b, e); end
        end
      end
    join
    lows = 0;
    repeat (150) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_cmp++; if (lows !== 0) begin n_bad++; $display("FAIL requeue_extra_line tx_low got %0d want 0", lows); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL requeue_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b, e;
    logic [15:0] p, l, a;
    logic [7:0] o, d, c, s;
    logic [4:0] t;
    int st, s1, s2, d1, k, d0, lows;
    bit ferr, tmo;
    p = 16'($urandom); l = 16'($urandom); a = 16'($urandom);
    o = 8'($urandom); d = 8'($urandom); c = 8'($urandom); s = 8'($urandom); t = 5'($urandom);
    exp_q.delete();
    set_taps(p, l, o, a, d, c, s, t);
    push_line(p, l, o, a, d, c, s, t, 1'b1);
    push_line(p, l, o, a, d, c, s, t, 1'b1);
    d0 = done_cnt; s1 = -1; s2 = -1; d1 = -1;
    @(posedge clk); #1; k = cyc; snap = 1'b1;
    for (int i = 0; i < 2 * LINE_LEN; i++) begin
      rx_byte(1'b0, b, st, ferr, tmo);
      if (tmo) begin
        n_cmp++; n_bad++; $display("FAIL b2b_timeout byte %0d", i);
        break;
      end
      if (i == 0) s1 = st;
      if (i == LINE_LEN) begin
        s2 = st; d1 = last_done_cyc; snap = 1'b0;
      end
      e = exp_q.pop_front();
      n_cmp++; if (b !== e) begin n_bad++; $display("FAIL b2b_char[%0d] got %h want %h", i, b, e); end
    end
    snap = 1'b0;
    lows = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    n_cmp++; if (s1 - k !== 1) begin n_bad++; $display("FAIL b2b_latency got %0d want 1", s1 - k); end
    n_cmp++; if (d1 - s1 !== LINE_CYC) begin n_bad++; $display("FAIL b2b_line_len got %0d want %0d", d1 - s1, LINE_CYC); end
    n_cmp++; if (s2 - d1 !== 1) begin n_bad++; $display("FAIL b2b_restart got %0d want 1", s2 - d1); end
    n_cmp++; if (done_cnt - d0 !== 2) begin n_bad++; $display("FAIL b2b_done got %0d want 2", done_cnt - d0); end
    n_cmp++; if (lows !== 0) begin n_bad++; $display("FAIL b2b_third_line tx_low got %0d want 0", lows); end
  endtask

  task automatic test_bounds();
    logic [7:0] b, e;
    logic [7:0] rx_buf [LINE_LEN];
    logic [15:0] p, l, a;
    logic [7:0] o, c, s;
    int st, ferrs;
    bit ferr, tmo;
    p = 16'($urandom); l = 16'($urandom); a = 16'($urandom);
    o = 8'($urandom); c = 8'($urandom); s = 8'($urandom);
    for (int i = 0; i < LINE_LEN; i++) rx_buf[i] = 8'h00;
    exp_q.delete();
    set_taps(p, l, o, a, 8'h00, c, s, 5'h1F);
    push_line(p, l, o, a, 8'h00, c, s, 5'h1F, 1'b1);
    ferrs = 0;
    @(posedge clk); #1; snap = 1'b1;
    @(posedge clk); #1; snap = 1'b0;
    for (int i = 0; i < LINE_LEN; i++) begin
      rx_byte(1'b0, b, st, ferr, tmo);
      if (tmo) begin
        n_cmp++; n_bad++; $display("FAIL bounds_timeout byte %0d", i);
        break;
      end
      if (ferr) ferrs++;
      rx_buf[i] = b;
      e = exp_q.pop_front();
      n_cmp++; if (b !== e) begin n_bad++; $display("FAIL bounds_char[%0d] got %h want %h", i, b, e); end
    end
    repeat (4) @(negedge clk);
    n_cmp++; if ({rx_buf[27], rx_buf[28]} !== 16'h3146) begin n_bad++; $display("FAIL bounds_t_field got %h%h want 3146", rx_buf[27], rx_buf[28]); end
    n_cmp++; if ({rx_buf[18], rx_buf[19]} !== 16'h3030) begin n_bad++; $display("FAIL bounds_d_field got %h%h want 3030", rx_buf[18], rx_buf[19]); end
    n_cmp++; if (ferrs !== 0) begin n_bad++; $display("FAIL bounds_bit_period bad_frames got %0d want 0", ferrs); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lowercase();
    test_no_requeue();
    test_back_to_back();
    test_bounds();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
